node_cache_arbiter: RTL and testbench

NODE_CACHE_ARBITER -- requirements
Module: node_cache_arbiter

---
 rtl/node_cache_arbiter_if.sv | 33 +++
 rtl/node_cache_arbiter.sv | 116 +++++++++++
 tb/tb_node_cache_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_cache_arbiter_if.sv
// Requester-side and cache-side bus of the node cache arbiter.
// The arbiter attaches through the slave modport; requesters and cache model use master.
interface node_cache_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    logic                      cache_en;
    logic                      cache_we;
    logic [ADDR_W-1:0]         cache_addr;
    logic [DATA_W-1:0]         cache_wdata;
    logic [DATA_W-1:0]         cache_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, cache_rdata,
        input  req_ready, rsp_valid, rsp_data, cache_en, cache_we, cache_addr, cache_wdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, cache_rdata,
        output req_ready, rsp_valid, rsp_data, cache_en, cache_we, cache_addr, cache_wdata
    );
endinterface

// File: rtl/node_cache_arbiter.sv
// Round-robin arbiter with lockable bursts in front of a single-port node cache.
// Grants are combinational; read responses return one cycle after the granted beat.
module node_cache_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64
) (
    input logic                 clk,
    input logic                 rst,
    node_cache_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] StArb    = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] rsp_q, rsp_d;

    logic               xfer;
    logic               xfer_out;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_we;
    logic               gnt_lock;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_wdata;

    // (base + k) mod NUM_REQ, valid for any NUM_REQ, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] base,
                                                 input int unsigned      k);
        int unsigned sum;
        sum = 32'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    always_comb begin
        gnt_idx = owner_q;
        xfer    = 1'b0;
        if (state_q == StLocked) begin
            xfer = bus.req_valid[owner_q];
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!xfer && bus.req_valid[ptr_inc(rr_ptr_q, k)]) begin
                    xfer    = 1'b1;
                    gnt_idx = ptr_inc(rr_ptr_q, k);
                end
            end
        end
    end

    // Outputs are forced quiet while reset is held, even if requesters stay valid.
    assign xfer_out = xfer & rst;

    always_comb begin
        grant = '0;
        if (xfer_out) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_we    = bus.req_we[gnt_idx];
        gnt_lock  = bus.req_lock[gnt_idx];
        gnt_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
        gnt_wdata = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        bus.req_ready   = grant;
        bus.cache_en    = xfer_out;
        bus.cache_we    = xfer_out & gnt_we;
        bus.cache_addr  = xfer_out ? gnt_addr : '0;
        bus.cache_wdata = xfer_out ? gnt_wdata : '0;
        bus.rsp_valid   = rsp_q;
        bus.rsp_data    = (|rsp_q) ? bus.cache_rdata : '0;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        rsp_d    = '0;
        if (xfer) begin
            if (gnt_lock) begin
                state_d = StLocked;
                owner_d = gnt_idx;
            end else begin
                state_d  = StArb;
                rr_ptr_d = ptr_inc(gnt_idx, 1);
            end
            if (!gnt_we) begin
                rsp_d[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StArb;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            rsp_q    <= rsp_d;
        end
    end
endmodule

// File: tb/tb_node_cache_arbiter.sv
// Scoreboard bench for node_cache_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration model and a shadow copy of the cache.
module tb_node_cache_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    node_cache_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    node_cache_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned i);
        return {i * 32'h9E37_79B9, ~i};
    endfunction

    // Synchronous single-port cache: read data valid the cycle after the read.
    logic [DW-1:0] cmem [1024];
    logic [DW-1:0] rdata_q;
    bit            cmem_init = 1'b0;
    assign bus.cache_rdata = rdata_q;

    always @(posedge clk) begin
        if (!cmem_init) begin
            for (int i = 0; i < 1024; i++) cmem[i] <= init_word(i);
            cmem_init <= 1'b1;
        end else if (bus.cache_en) begin
            if (bus.cache_we) cmem[bus.cache_addr] <= bus.cache_wdata;
            else rdata_q <= cmem[bus.cache_addr];
        end
    end

    typedef struct {
        int unsigned   idx;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [1024];
    bit            m_locked;
    int unsigned   m_ptr;
    int unsigned   m_owner;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  last_rsp_valid = '0;
    logic [DW-1:0] last_rsp_data  = '0;
    logic [N-1:0]  got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_cache_en"}, 64'(bus.cache_en), 64'd0);
        chk({tag, "_cache_we"}, 64'(bus.cache_we), 64'd0);
        chk({tag, "_cache_addr"}, 64'(bus.cache_addr), 64'd0);
        chk({tag, "_cache_wdata"}, bus.cache_wdata, 64'd0);
    endtask

    // One clock of stimulus; checks the grant and cache port against the model and
    // queues the expected read response.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0] we,
                               input logic [N-1:0] lk, input logic [N*AW-1:0] addr,
                               input logic [N*DW-1:0] wd, output logic [N-1:0] ready);
        bit            found;
        int unsigned   gi;
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_lock  = lk;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        #4;
        ready = bus.req_ready;
        found = 1'b0;
        gi    = 0;
        if (m_locked) begin
            if (v[m_owner]) begin
                found = 1'b1;
                gi    = m_owner;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int unsigned i;
                i = (m_ptr + k) % N;
                if (!found && v[i]) begin
                    found = 1'b1;
                    gi    = i;
                end
            end
        end
        exp_ready = '0;
        if (found) exp_ready[gi] = 1'b1;
        chk("ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("cache_en", 64'(bus.cache_en), 64'(found));
        if (found) begin
            a = addr[gi*AW +: AW];
            d = wd[gi*DW +: DW];
            chk("cache_we", 64'(bus.cache_we), 64'(we[gi]));
            chk("cache_addr", 64'(bus.cache_addr), 64'(a));
            if (we[gi]) begin
                chk("cache_wdata", bus.cache_wdata, d);
                shadow[a] = d;
            end else begin
                exp_q.push_back('{idx: gi, data: shadow[a]});
            end
            if (lk[gi]) begin
                m_locked = 1'b1;
                m_owner  = gi;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (gi + 1) % N;
            end
        end else begin
            chk("cache_we_idle", 64'(bus.cache_we), 64'd0);
        end
    endtask

    // Same address and data presented by every requester.
    task automatic dc(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                      input int unsigned a, input logic [DW-1:0] d, output logic [N-1:0] ready);
        logic [N*AW-1:0] av;
        logic [N*DW-1:0] dv;
        for (int i = 0; i < N; i++) begin
            av[i*AW +: AW] = AW'(a);
            dv[i*DW +: DW] = d;
        end
        drive_cycle(v, we, lk, av, dv, ready);
    endtask

    // Called right after drive_cycle: reset lands just after the edge that launched
    // any pending read, so that response must never appear.
    task automatic reset_now(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_quiet(tag);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        model_reset();
        bus.req_valid = '1;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        fork
            forever begin
                rsp_t e;
                @(negedge clk);
                if (bus.rsp_valid !== '0 || exp_q.size() != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1 << e.idx);
                        chk("rsp_data", bus.rsp_data, e.data);
                    end
                    last_rsp_valid = bus.rsp_valid;
                    last_rsp_data  = bus.rsp_data;
                end
            end
        join_none

        #3;
        check_quiet("por");
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Plain round robin with everyone reading.
        for (int c = 0; c < 5; c++) begin
            dc(4'b1111, 4'b0000, 4'b0000, 16 + c, '0, got);
            chk("rr_seq", 64'(got), 64'd1 << (c % 4));
        end

        // Write then read of the same address from different requesters.
        dc(4'b0010, 4'b0010, 4'b0000, 5, 64'hA5, got);
        dc(4'b0100, 4'b0000, 4'b0000, 5, '0, got);
        dc(4'b0000, 4'b0000, 4'b0000, 0, '0, got);
        chk("raw_rsp_valid", 64'(last_rsp_valid), 64'b0100);
        chk("raw_rsp_data", last_rsp_data, 64'hA5);

        // Eight-beat locked burst by requester 1 while 0 and 3 wait.
        dc(4'b0010, 4'b0000, 4'b0010, 32, '0, got);
        chk("lock_beat1", 64'(got), 64'b0010);
        for (int b = 2; b <= 8; b++) begin
            dc(4'b1011, 4'b0000, (b < 8) ? 4'b1011 : 4'b1001, 32 + b, '0, got);
            chk("lock_beat", 64'(got), 64'b0010);
        end
        dc(4'b1001, 4'b0000, 4'b0000, 48, '0, got);
        chk("after_lock_req3", 64'(got), 64'b1000);
        dc(4'b1001, 4'b0000, 4'b0000, 49, '0, got);
        chk("after_lock_req0", 64'(got), 64'b0001);

        // Owner goes idle mid-burst: nobody else may slip in.
        dc(4'b0010, 4'b0000, 4'b0010, 60, '0, got);
        for (int c = 0; c < 3; c++) begin
            dc(4'b1001, 4'b0000, 4'b0000, 61, '0, got);
            chk("lock_idle_ready", 64'(got), 64'd0);
            chk("lock_idle_en", 64'(bus.cache_en), 64'd0);
        end
        dc(4'b1011, 4'b0000, 4'b0000, 62, '0, got);
        chk("lock_resume", 64'(got), 64'b0010);

        // Reset during a lock with a read in flight.
        dc(4'b0010, 4'b0000, 4'b0010, 70, '0, got);
        dc(4'b0110, 4'b0000, 4'b0010, 71, '0, got);
        reset_now("midlock");
        dc(4'b1111, 4'b0000, 4'b0000, 72, '0, got);
        chk("post_reset_req0", 64'(got), 64'b0001);

        // Randomized traffic over a small address window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0]    v, we, lk;
            logic [N*AW-1:0] av;
            logic [N*DW-1:0] dv;
            v  = N'($urandom_range(0, 15));
            we = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                lk[i]          = ($urandom_range(0, 3) == 0);
                av[i*AW +: AW] = AW'($urandom_range(0, 15));
                dv[i*DW +: DW] = {$urandom, $urandom};
            end
            drive_cycle(v, we, lk, av, dv, got);
            if (c == 1500) reset_now("rand");
        end

        dc(4'b0000, 4'b0000, 4'b0000, 0, '0, got);
        dc(4'b0000, 4'b0000, 4'b0000, 0, '0, got);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
